// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared definitions for the SD-card SPI port (I/O ports 6Ch-6Fh).
//   spiState_t     : shifter FSM state (IDLE / LO / HI half of SCLK)
//   PORT_*         : I/O addresses served by the block
//   STAT_*         : bit positions inside the status byte
//   statusByte()   : packs the status byte from its component flags
package sd_spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } spiState_t;

    localparam logic [7:0] PORT_DATA   = 8'h6C;
    localparam logic [7:0] PORT_CLK    = 8'h6D;
    localparam logic [7:0] PORT_SELECT = 8'h6E;
    localparam logic [7:0] PORT_STATUS = 8'h6F;

    localparam int STAT_BUSY = 0;
    localparam int STAT_CDA  = 1;
    localparam int STAT_CDB  = 2;
    localparam int STAT_FAST = 3;

    function automatic logic [7:0] statusByte(input logic busy, input logic cdA,
                                              input logic cdB, input logic fast);
        logic [7:0] s;
        s            = 8'h00;
        s[STAT_BUSY] = busy;
        s[STAT_CDA]  = cdA;
        s[STAT_CDB]  = cdB;
        s[STAT_FAST] = fast;
        return s;
    endfunction

endpackage

// File: rtl/sd_spi_shifter.sv
// sd_spi_shifter: one-byte SPI mode-0 shift engine (MSB first).
//   clock, reset : system clock, synchronous active-high reset
//   start        : one-cycle request; accepted only while idle
//   fastSel      : selects FAST_DIV instead of SLOW_DIV, latched at start
//   din          : byte to send, latched at start
//   miso         : card data, sampled at each SCLK rising edge
//   dout         : last received byte (8'hFF after reset)
//   busy         : transfer in progress
//   sclk, mosi   : SPI clock (idle low) and data (idle high)
import sd_spi_pkg::*;

module sd_spi_shifter #(
    parameter int SLOW_DIV = 63,
    parameter int FAST_DIV = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       fastSel,
    input  logic [7:0] din,
    input  logic       miso,
    output logic [7:0] dout,
    output logic       busy,
    output logic       sclk,
    output logic       mosi
);

    localparam int MAXDIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int DW     = (MAXDIV < 1) ? 1 : $clog2(MAXDIV + 1);

    spiState_t   state, nextState;
    logic [DW-1:0] divCnt, divReg;
    logic [2:0]  bitCnt;
    logic [7:0]  shifter, rxReg;
    logic        misoBit;
    logic        divDone, lastBit;
    logic        doLoad, doSample, doShift, doFinish;

    assign divDone = (divCnt == divReg);
    assign lastBit = (bitCnt == 3'd7);
    assign dout    = rxReg;

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start)   nextState = LO;
            LO:      if (divDone) nextState = HI;
            HI:      if (divDone) nextState = lastBit ? IDLE : LO;
            default: nextState = IDLE;
        endcase
    end

    // outputs and datapath strobes; SCLK is simply "in the HI half"
    always_comb begin
        sclk     = (state == HI);
        busy     = (state != IDLE);
        doLoad   = (state == IDLE) && start;
        doSample = (state == LO) && divDone;
        doShift  = (state == HI) && divDone && !lastBit;
        doFinish = (state == HI) && divDone && lastBit;
    end

    // datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            divCnt  <= '0;
            divReg  <= '0;
            bitCnt  <= '0;
            shifter <= 8'h00;
            misoBit <= 1'b0;
            rxReg   <= 8'hFF;
            mosi    <= 1'b1;
        end else begin
            if (state == IDLE || divDone) divCnt <= '0;
            else                          divCnt <= divCnt + 1'b1;

            if (doLoad) begin
                shifter <= din;
                mosi    <= din[7];
                bitCnt  <= '0;
                divReg  <= fastSel ? DW'(FAST_DIV) : DW'(SLOW_DIV);
            end
            if (doSample) misoBit <= miso;
            if (doShift) begin
                shifter <= {shifter[6:0], misoBit};
                mosi    <= shifter[6];
                bitCnt  <= bitCnt + 3'd1;
            end
            if (doFinish) begin
                rxReg <= {shifter[6:0], misoBit};
                mosi  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_spi_port.sv
// sd_spi_port: SD-card SPI master behind I/O ports 6Ch-6Fh, two sockets A/B.
//   clock, reset        : system clock, synchronous active-high reset
//   cpuDataOut          : CPU write data
//   *_cs                : decoded port chip-selects (level, whole I/O cycle)
//   sdMISO              : card data out (used unsynchronized)
//   sdCD_A_n, sdCD_B_n  : card-detect pins, active-low, asynchronous
//   sdDataIn            : read data to the CPU input mux
//   sdSCLK, sdMOSI      : SPI clock / data
//   sdCS_A_n, sdCS_B_n  : card selects, active-low
// Build option: define SD_CARD_DETECT_EN to synchronize the card-detect pins
// into status bits 1/2; otherwise those bits read 0 and the pins are ignored.
import sd_spi_pkg::*;

module sd_spi_port #(
    parameter int SLOW_DIV = 63,
    parameter int FAST_DIV = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] cpuDataOut,
    input  logic       DataToSD_cs,
    input  logic       DataFmSD_cs,
    input  logic       SD_Clk_cs,
    input  logic       SD_Card_select_cs,
    input  logic       SD_status_cs,
    input  logic       SDWrite_cs,
    input  logic       SDRead_cs,
    input  logic       sdMISO,
    input  logic       sdCD_A_n,
    input  logic       sdCD_B_n,
    output logic [7:0] sdDataIn,
    output logic       sdSCLK,
    output logic       sdMOSI,
    output logic       sdCS_A_n,
    output logic       sdCS_B_n
);

    logic [7:0] txReg, rxReg;
    logic       fastMode, selA, selB;
    logic       wrHist, rdHist, wrRise, rdRise;
    logic       busy, cdA, cdB;

    always_ff @(posedge clock) begin
        if (reset) begin
            txReg    <= 8'h00;
            fastMode <= 1'b0;
            selA     <= 1'b0;
            selB     <= 1'b0;
            wrHist   <= 1'b0;
            rdHist   <= 1'b0;
        end else begin
            if (DataToSD_cs) txReg <= cpuDataOut;
            if (SD_Clk_cs)   fastMode <= cpuDataOut[0];
            if (SD_Card_select_cs) begin
                selA <= cpuDataOut[0];
                selB <= cpuDataOut[1];
            end
            wrHist <= SDWrite_cs;
            rdHist <= SDRead_cs;
        end
    end

    // one trigger per I/O cycle regardless of how long the cs is held
    assign wrRise = SDWrite_cs & ~wrHist;
    assign rdRise = SDRead_cs  & ~rdHist;

    sd_spi_shifter #(.SLOW_DIV(SLOW_DIV), .FAST_DIV(FAST_DIV)) uShifter (
        .clock   (clock),
        .reset   (reset),
        .start   (wrRise | rdRise),
        .fastSel (fastMode),
        .din     (wrRise ? txReg : 8'hFF),
        .miso    (sdMISO),
        .dout    (rxReg),
        .busy    (busy),
        .sclk    (sdSCLK),
        .mosi    (sdMOSI)
    );

    assign sdCS_A_n = ~selA;
    assign sdCS_B_n = ~selB;

`ifdef SD_CARD_DETECT_EN
    // flops hold "present" so the reset value 0 reads as no card
    logic [1:0] cdASync, cdBSync;
    always_ff @(posedge clock) begin
        if (reset) begin
            cdASync <= 2'b00;
            cdBSync <= 2'b00;
        end else begin
            cdASync <= {cdASync[0], ~sdCD_A_n};
            cdBSync <= {cdBSync[0], ~sdCD_B_n};
        end
    end
    assign cdA = cdASync[1];
    assign cdB = cdBSync[1];
`else
    logic unusedCd;
    assign unusedCd = sdCD_A_n ^ sdCD_B_n;
    assign cdA = 1'b0;
    assign cdB = 1'b0;
`endif

    // rxReg has priority if both read selects are high
    always_comb begin
        sdDataIn = 8'h00;
        if (DataFmSD_cs)       sdDataIn = rxReg;
        else if (SD_status_cs) sdDataIn = statusByte(busy, cdA, cdB, fastMode);
    end

endmodule
